// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU that stalls the pipeline while it iterates.
// Define DIV_FASTPATH_EN to resolve divide-by-zero and signed overflow without iterating.
module div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  E_is_div,
    input  logic [1:0]            E_div_op,
    input  logic [DATA_WIDTH-1:0] E_a,
    input  logic [DATA_WIDTH-1:0] E_b,
    input  logic [4:0]            E_rd,
    input  logic                  flush,
    output logic                  div_busy,
    output logic                  div_done,
    output logic [DATA_WIDTH-1:0] div_result,
    output logic [4:0]            div_rd,
    output logic [1:0]            dbg_state
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] rem_r, quo_r, dvsr_r, dvnd_r, result_r;
    logic [1:0]            op_r;
    logic [4:0]            rd_r;
    logic                  neg_quo_r, neg_rem_r, special_r;

    logic                  start, is_signed, a_neg, b_neg, b_zero, overflow, special, last_step;
    logic [DATA_WIDTH-1:0] a_mag, b_mag;

    logic [DATA_WIDTH:0]   shifted, diff;
    logic [DATA_WIDTH-1:0] rem_next, quo_next, quo_signed, rem_signed, calc_result;

    // Results the architecture defines for divide-by-zero and most-negative / -1.
    function automatic logic [DATA_WIDTH-1:0] special_value(input logic [1:0] op,
                                                           input logic [DATA_WIDTH-1:0] dividend,
                                                           input logic zero_div);
        if (zero_div) special_value = op[1] ? dividend : '1;
        else          special_value = op[1] ? '0 : dividend;
    endfunction

    // Handshake: div_busy high means the requester holds E_* stable; E_is_div is only
    // accepted in IDLE, and div_done is a one-cycle strobe qualifying div_result/div_rd.
    assign start     = (state == IDLE) && E_is_div && !flush;
    assign is_signed = !E_div_op[0];
    assign a_neg     = is_signed && E_a[DATA_WIDTH-1];
    assign b_neg     = is_signed && E_b[DATA_WIDTH-1];
    assign a_mag     = a_neg ? -E_a : E_a;
    assign b_mag     = b_neg ? -E_b : E_b;
    assign b_zero    = (E_b == '0);
    assign overflow  = is_signed && (E_a == MIN_NEG) && (E_b == '1);
    assign special   = b_zero || overflow;
    assign last_step = (count == CW'(1));

    // One restoring step: the quotient register shifts its MSB into the partial remainder.
    always_comb begin
        shifted = {rem_r, quo_r[DATA_WIDTH-1]};
        diff    = shifted - {1'b0, dvsr_r};
        if (!diff[DATA_WIDTH]) begin
            rem_next = diff[DATA_WIDTH-1:0];
            quo_next = {quo_r[DATA_WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[DATA_WIDTH-1:0];
            quo_next = {quo_r[DATA_WIDTH-2:0], 1'b0};
        end
        quo_signed = neg_quo_r ? -quo_next : quo_next;
        rem_signed = neg_rem_r ? -rem_next : rem_next;
        if (special_r) calc_result = special_value(op_r, dvnd_r, dvsr_r == '0);
        else           calc_result = op_r[1] ? rem_signed : quo_signed;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef DIV_FASTPATH_EN
                    state_next = special ? DONE : CALC;
`else
                    state_next = CALC;
`endif
                end
            end
            CALC: begin
                if (flush)          state_next = IDLE;
                else if (last_step) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            dvsr_r    <= '0;
            dvnd_r    <= '0;
            result_r  <= '0;
            op_r      <= '0;
            rd_r      <= '0;
            neg_quo_r <= 1'b0;
            neg_rem_r <= 1'b0;
            special_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r      <= E_div_op;
                        rd_r      <= E_rd;
                        dvnd_r    <= E_a;
                        dvsr_r    <= b_mag;
                        rem_r     <= '0;
                        quo_r     <= a_mag;
                        neg_quo_r <= a_neg ^ b_neg;
                        neg_rem_r <= a_neg;
                        special_r <= special;
                        count     <= CW'(DATA_WIDTH);
`ifdef DIV_FASTPATH_EN
                        if (special) begin
                            count    <= '0;
                            result_r <= special_value(E_div_op, E_a, b_zero);
                        end
`endif
                    end
                end
                CALC: begin
                    if (flush) begin
                        count <= '0;
                    end else begin
                        rem_r <= rem_next;
                        quo_r <= quo_next;
                        count <= count - CW'(1);
                        if (last_step) result_r <= calc_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_busy   = !rst && ((state == CALC) || start);
    assign div_done   = !rst && (state == DONE) && !flush;
    assign div_result = result_r;
    assign div_rd     = rd_r;
    assign dbg_state  = state;
endmodule

// File: tb/tb_div_unit.sv
// Directed and random bench for div_unit: expected results queued at issue, compared on div_done.
// Build with DIV_FASTPATH_EN defined to expect single-cycle special-case latency.
module tb_div_unit;
    localparam int W = 32;
    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
    localparam int ST_IDLE = 0, ST_CALC = 1, ST_DONE = 2;
    localparam int NOM_LAT = W + 1;
`ifdef DIV_FASTPATH_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = W + 1;
`endif

    logic         clk = 1'b0;
    logic         rst, E_is_div, flush;
    logic [1:0]   E_div_op;
    logic [W-1:0] E_a, E_b;
    logic [4:0]   E_rd;
    logic         div_busy, div_done;
    logic [W-1:0] div_result;
    logic [4:0]   div_rd;
    logic [1:0]   dbg_state;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    logic [4:0]   exp_rd_q[$];

    div_unit #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .E_is_div(E_is_div), .E_div_op(E_div_op),
        .E_a(E_a), .E_b(E_b), .E_rd(E_rd), .flush(flush),
        .div_busy(div_busy), .div_done(div_done), .div_result(div_result),
        .div_rd(div_rd), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference behaviour written from the instruction semantics, not from the datapath.
    function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic sgn;
        sgn = !op[0];
        if (b == '0) return op[1] ? a : '1;
        if (sgn && a == {1'b1, {(W-1){1'b0}}} && b == '1) return op[1] ? '0 : a;
        if (sgn) return op[1] ? W'($signed(a) % $signed(b)) : W'($signed(a) / $signed(b));
        return op[1] ? (a % b) : (a / b);
    endfunction

    // Called just after a falling edge; holds E_is_div through the DONE cycle like the pipeline does.
    task automatic run_div(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [4:0] rd, input logic [W-1:0] exp_res,
                           input int exp_lat, input string tag);
        int cycles;
        int busy_cycles;
        exp_q.push_back(exp_res);
        exp_rd_q.push_back(rd);
        E_is_div = 1'b1;
        E_div_op = op;
        E_a = a;
        E_b = b;
        E_rd = rd;
        #1;
        busy_cycles = div_busy ? 1 : 0;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (!div_done && div_busy) busy_cycles++;
        end while (!div_done && cycles < 100);
        check({tag, " done_latency"}, W'(cycles), W'(exp_lat));
        check({tag, " stall_cycles"}, W'(busy_cycles), W'(exp_lat));
        check({tag, " busy_in_done"}, W'(div_busy), W'(0));
        check({tag, " result"}, div_result, exp_q.pop_front());
        check({tag, " rd"}, W'(div_rd), W'(exp_rd_q.pop_front()));
        @(negedge clk);
        E_is_div = 1'b0;
        #1;
        check({tag, " done_one_cycle"}, W'(div_done), W'(0));
        check({tag, " no_restart"}, W'(dbg_state), W'(ST_IDLE));
    endtask

    initial begin
        logic [1:0]   r_op;
        logic [W-1:0] r_a, r_b;
        int           r_lat;
        logic         seen_done;

        rst = 1'b1; E_is_div = 1'b1; flush = 1'b0;
        E_div_op = OP_DIV; E_a = 32'd5; E_b = 32'd1; E_rd = 5'd3;
        @(negedge clk);
        check("reset busy", W'(div_busy), W'(0));
        check("reset done", W'(div_done), W'(0));
        @(negedge clk);
        rst = 1'b0; E_is_div = 1'b0;
        #1;
        check("reset state", W'(dbg_state), W'(ST_IDLE));
        check("reset result", div_result, '0);
        check("reset rd", W'(div_rd), W'(0));
        check("reset idle busy", W'(div_busy), W'(0));

        run_div(OP_DIV,  32'd100, 32'hFFFF_FFF9, 5'd1, 32'hFFFF_FFF2, NOM_LAT, "div 100/-7");
        run_div(OP_REM,  32'd100, 32'hFFFF_FFF9, 5'd2, 32'd2,         NOM_LAT, "rem 100/-7");
        run_div(OP_DIV,  32'hFFFF_FF9C, 32'd7,   5'd3, 32'hFFFF_FFF2, NOM_LAT, "div -100/7");
        run_div(OP_REM,  32'hFFFF_FF9C, 32'd7,   5'd4, 32'hFFFF_FFFE, NOM_LAT, "rem -100/7");
        run_div(OP_DIVU, 32'hFFFF_FFFF, 32'd0,   5'd5, 32'hFFFF_FFFF, SPECIAL_LAT, "divu by0");
        run_div(OP_REMU, 32'h0000_1234, 32'd0,   5'd6, 32'h0000_1234, SPECIAL_LAT, "remu by0");
        run_div(OP_DIV,  32'hFFFF_FFFB, 32'd0,   5'd7, 32'hFFFF_FFFF, SPECIAL_LAT, "div -5 by0");
        run_div(OP_REM,  32'hFFFF_FFFB, 32'd0,   5'd8, 32'hFFFF_FFFB, SPECIAL_LAT, "rem -5 by0");
        run_div(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h8000_0000, SPECIAL_LAT, "div ovf");
        run_div(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0,         SPECIAL_LAT, "rem ovf");
        run_div(OP_REMU, 32'h8000_0000, 32'd3,         5'd11, 32'd2,         NOM_LAT, "remu min/3");

        for (int i = 0; i < 6; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            r_b  = (i % 2 == 1) ? W'($urandom_range(1, 1000)) : $urandom;
            r_lat = (r_b == '0 || (!r_op[0] && r_a == 32'h8000_0000 && r_b == '1)) ? SPECIAL_LAT : NOM_LAT;
            run_div(r_op, r_a, r_b, 5'(16 + i), model(r_op, r_a, r_b), r_lat, "random");
        end

        // Kill an operation at CALC cycle 10, then issue a fresh divide straight away.
        E_is_div = 1'b1; E_div_op = OP_DIV; E_a = 32'd1000; E_b = 32'd3; E_rd = 5'd25;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush calc done", W'(div_done), W'(0));
        check("flush calc state", W'(dbg_state), W'(ST_CALC));
        @(negedge clk);
        flush = 1'b0; E_is_div = 1'b0;
        #1;
        check("after flush busy", W'(div_busy), W'(0));
        check("after flush done", W'(div_done), W'(0));
        check("after flush state", W'(dbg_state), W'(ST_IDLE));
        run_div(OP_DIVU, 32'd9, 32'd2, 5'd12, 32'd4, NOM_LAT, "divu 9/2 after flush");

        // Flush landing on the DONE cycle suppresses the strobe.
        E_is_div = 1'b1; E_div_op = OP_DIVU; E_a = 32'd50; E_b = 32'd5; E_rd = 5'd13;
        repeat (NOM_LAT) @(negedge clk);
        flush = 1'b1; E_is_div = 1'b0;
        #1;
        check("flush done state", W'(dbg_state), W'(ST_DONE));
        check("flush done strobe", W'(div_done), W'(0));
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("after done flush state", W'(dbg_state), W'(ST_IDLE));
        check("after done flush done", W'(div_done), W'(0));

        // Reset in the middle of CALC abandons the operation.
        E_is_div = 1'b1; E_div_op = OP_DIV; E_a = 32'hFFFF_FFB3; E_b = 32'd5; E_rd = 5'd21;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid reset busy", W'(div_busy), W'(0));
        check("mid reset done", W'(div_done), W'(0));
        @(negedge clk);
        rst = 1'b0; E_is_div = 1'b0;
        #1;
        check("post reset state", W'(dbg_state), W'(ST_IDLE));
        check("post reset result", div_result, '0);
        check("post reset rd", W'(div_rd), W'(0));
        check("post reset busy", W'(div_busy), W'(0));
        seen_done = 1'b0;
        repeat (NOM_LAT + 2) begin
            @(negedge clk);
            if (div_done) seen_done = 1'b1;
        end
        check("no done after reset", W'(seen_done), W'(0));
        run_div(OP_DIV, 32'd7, 32'd2, 5'd30, 32'd3, NOM_LAT, "div 7/2 after reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: DATA_WIDTH, 32, operand/result width.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 E_is_div  input  1  divide request from decode/execute pipeline register.
REQ-005 E_div_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 E_a  input  DATA_WIDTH  dividend (forwarded rs1).
REQ-007 E_b  input  DATA_WIDTH  divisor (forwarded rs2).
REQ-008 E_rd  input  5  destination register of the request.
REQ-009 flush  input  1  kill the in-flight or requesting divide.
REQ-010 div_busy  output  1  pipeline stall request.
REQ-011 div_done  output  1  result-valid pulse.
REQ-012 div_result  output  DATA_WIDTH  quotient or remainder per latched op.
REQ-013 div_rd  output  5  latched destination register.

Function
REQ-014 FSM states SHALL be IDLE, CALC, DONE.
REQ-015 IDLE with E_is_div=1 and flush=0 SHALL be a start: latch op, E_rd, operand magnitudes and signs (signed ops only); load iteration counter with DATA_WIDTH; go to CALC.
REQ-016 CALC SHALL perform one restoring shift-subtract step per cycle, decrement the counter, and go to DONE on the step where the counter reaches 0 (exactly DATA_WIDTH CALC cycles).
REQ-017 DONE SHALL last exactly one cycle, then go to IDLE; E_is_div SHALL be ignored in DONE (same instruction still present).
REQ-018 div_busy SHALL equal (state==CALC) or (state==IDLE and E_is_div and not flush), combinationally.
REQ-019 div_done SHALL equal (state==DONE and not flush); div_result and div_rd SHALL be stable whenever div_done=1.
REQ-020 Nominal latency: start sampled at edge T -> div_done high in the cycle after edge T+DATA_WIDTH; stall = DATA_WIDTH+1 cycles.
REQ-021 Signed quotient SHALL be negated when operand signs differ; signed remainder SHALL take the dividend's sign.
REQ-022 Divisor zero: quotient SHALL be all ones (DIV and DIVU), remainder SHALL equal the dividend.
REQ-023 Signed overflow (dividend = most-negative, divisor = -1): quotient SHALL equal the dividend, remainder SHALL be 0.
REQ-024 flush=1 in CALC SHALL return to IDLE at the next edge with no div_done.
REQ-025 flush=1 in DONE SHALL suppress div_done; the state still returns to IDLE.
REQ-026 Back-to-back divides SHALL be separated by at least the DONE cycle; a new start is accepted only in IDLE.

Reset
REQ-027 rst=1 SHALL force state IDLE, counter 0, internal remainder/quotient 0, div_result 0, div_rd 0; div_done and div_busy SHALL be 0 during the reset cycle.
REQ-028 rst asserted mid-CALC SHALL abandon the operation without div_done.

Configuration
REQ-029 Macro DIV_FASTPATH_EN defined: a start with divisor zero or signed overflow SHALL go IDLE -> DONE directly (div_busy high for the start cycle only, div_done in the next cycle) with the REQ-022/023 results.
REQ-030 Macro DIV_FASTPATH_EN undefined: those cases SHALL take the full REQ-020 latency and produce the REQ-022/023 results via final override.

Verification
REQ-031 DIV 100 / -7 -> div_result 0xFFFFFFF2 (-14); REM same operands -> 2; div_done exactly DATA_WIDTH+1 cycles after start, one cycle wide.
REQ-032 DIVU 0xFFFFFFFF / 0 -> 0xFFFFFFFF; REMU 0x1234 / 0 -> 0x1234; with DIV_FASTPATH_EN, done in the next cycle, otherwise after full latency.
REQ-033 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; REMU 0x80000000 / 3 -> 2.
REQ-034 flush at CALC cycle 10 -> no div_done, div_busy low next cycle; a new DIVU 9/2 starting immediately -> 4 with correct div_rd.
REQ-035 rst at CALC cycle 5 -> all outputs 0 next cycle, IDLE; E_is_div held high through DONE -> only one div_done, no restart.
